// File: rtl/svm_pkg.sv
// svm_pkg: shared types and helpers for the sequential SVM classifier.
//   state_e  - controller states
//   npairs   - number of one-vs-one pairs for C classes
//   pair_lo  - lower class index of pair p
//   pair_hi  - higher class index of pair p
//   acc_w    - accumulator width that can never wrap
//   sat      - signed saturation of a 64-bit value to w bits
package svm_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_L1     = 3'd1,
        S_L2     = 3'd2,
        S_VOTE   = 3'd3,
        S_ARGMAX = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    function automatic int npairs(input int c);
        return (c * (c - 1)) / 2;
    endfunction

    // Pairs are enumerated (0,1),(0,2),..,(0,C-1),(1,2),..,(C-2,C-1).
    function automatic int pair_lo(input int p, input int c);
        int k;
        int lo;
        k  = 0;
        lo = 0;
        for (int i = 0; i < c; i++) begin
            for (int j = i + 1; j < c; j++) begin
                if (k == p) begin
                    lo = i;
                end
                k++;
            end
        end
        return lo;
    endfunction

    function automatic int pair_hi(input int p, input int c);
        int k;
        int hi;
        k  = 0;
        hi = 0;
        for (int i = 0; i < c; i++) begin
            for (int j = i + 1; j < c; j++) begin
                if (k == p) begin
                    hi = j;
                end
                k++;
            end
        end
        return hi;
    endfunction

    // Product width plus enough guard bits for max(DIMS,INTER) terms and the bias.
    function automatic int acc_w(input int w, input int dims, input int inter);
        int m;
        m = (dims > inter) ? dims : inter;
        return 2 * w + $clog2(m + 1);
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/svm_seq_if.sv
// svm_seq_if: feature-in / class-out handshake bundle.
//   din, in_valid_i, in_ready_o      - input vector handshake
//   class_o, out_valid_o, out_ready_i - result handshake
// master: the front-end/consumer side; slave: the classifier.
interface svm_seq_if #(
    parameter int W       = 16,
    parameter int DIMS    = 21,
    parameter int CLASSES = 3
);
    localparam int CW = $clog2(CLASSES);

    logic [DIMS-1:0][W-1:0] din;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [CW-1:0]          class_o;
    logic                   out_valid_o;
    logic                   out_ready_i;

    modport master (output din, in_valid_i, out_ready_i,
                    input  in_ready_o, class_o, out_valid_o);
    modport slave  (input  din, in_valid_i, out_ready_i,
                    output in_ready_o, class_o, out_valid_o);
endinterface

// File: rtl/svm_mac.sv
// svm_mac: shared signed multiply-accumulate unit.
//   en_i    - accumulate this cycle
//   first_i - start a new sum from bias_i<<<FRAC instead of the held value
//   a_i/b_i - W-bit signed operands
//   hid_o   - sat_W((sum)>>>FRAC), ReLU-clamped when RELU=1 (sum includes this cycle)
//   pos_o   - sum including this cycle is strictly positive
module svm_mac
    import svm_pkg::*;
#(
    parameter int W     = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 37,
    parameter int RELU  = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                first_i,
    input  logic signed [W-1:0] bias_i,
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] hid_o,
    output logic                pos_o
);
    logic signed [2*W-1:0]   prod_s;
    logic signed [ACC_W-1:0] base_s;
    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] shr_s;
    logic signed [63:0]      sat_s;
    logic signed [W-1:0]     clip_s;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    // Product, preload/accumulate sum, and the shift/saturate/ReLU output path.
    // The output reflects the sum including the current product so the final
    // term and the write-back happen in the same cycle.
    always_comb begin
        prod_s = a_i * b_i;
        if (first_i) begin
            base_s = ACC_W'(bias_i) <<< FRAC;
        end else begin
            base_s = acc_q;
        end
        sum_s  = base_s + ACC_W'(prod_s);
        shr_s  = sum_s >>> FRAC;
        sat_s  = sat(64'(shr_s), W);
        clip_s = W'(sat_s);
        if ((RELU != 0) && clip_s[W-1]) begin
            hid_o = '0;
        end else begin
            hid_o = clip_s;
        end
        pos_o = !sum_s[ACC_W-1] && (sum_s != '0);
        if (en_i) begin
            acc_d = sum_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/svm_seq.sv
// svm_seq: sequential two-layer one-vs-one SVM classifier.
//   clk_i, rst_i        - clock, asynchronous active-high reset
//   feats, biases       - layer-1 weights [d][h] and biases [h]
//   feats2, biases2     - score weights [h][p] and biases [p]
//   bus (slave)         - din/in_valid_i/in_ready_o and class_o/out_valid_o/out_ready_i
// Configuration ports are read live and must be held stable for the whole job.
module svm_seq
    import svm_pkg::*;
#(
    parameter int W       = 16,
    parameter int FRAC    = 8,
    parameter int DIMS    = 21,
    parameter int INTER   = 6,
    parameter int CLASSES = 3,
    parameter int RELU    = 0
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic [DIMS-1:0][INTER-1:0][W-1:0]               feats,
    input  logic [INTER-1:0][W-1:0]                         biases,
    input  logic [INTER-1:0][npairs(CLASSES)-1:0][W-1:0]    feats2,
    input  logic [npairs(CLASSES)-1:0][W-1:0]               biases2,
    svm_seq_if.slave                                        bus
);
    localparam int NP    = npairs(CLASSES);
    localparam int ACC_W = acc_w(W, DIMS, INTER);
    localparam int CW    = $clog2(CLASSES);
    localparam int DW    = (DIMS > 1) ? $clog2(DIMS) : 1;
    localparam int HW    = (INTER > 1) ? $clog2(INTER) : 1;
    localparam int PW    = (NP > 1) ? $clog2(NP) : 1;

    localparam logic [DW-1:0] D_LAST = DW'(DIMS - 1);
    localparam logic [HW-1:0] H_LAST = HW'(INTER - 1);
    localparam logic [PW-1:0] P_LAST = PW'(NP - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLASSES - 1);

    state_e                          state_q, state_d;
    logic [DIMS-1:0][W-1:0]          din_q, din_d;
    logic [DW-1:0]                   d_q, d_d;
    logic [HW-1:0]                   h_q, h_d;
    logic [PW-1:0]                   p_q, p_d;
    logic [CW-1:0]                   c_q, c_d;
    logic [INTER-1:0][W-1:0]         hidden_q, hidden_d;
    logic [NP-1:0]                   win_q, win_d;
    logic [CLASSES-1:0][CW-1:0]      votes_q, votes_d;
    logic [CW-1:0]                   best_q, best_d;
    logic [CW-1:0]                   bestv_q, bestv_d;
    logic [CW-1:0]                   class_q, class_d;
    logic                            out_valid_q, out_valid_d;
    logic                            in_ready_q, in_ready_d;

    logic                            mac_en_s;
    logic                            mac_first_s;
    logic signed [W-1:0]             mac_a_s;
    logic signed [W-1:0]             mac_b_s;
    logic signed [W-1:0]             mac_bias_s;
    logic signed [W-1:0]             hid_s;
    logic                            pos_s;
    logic [CW-1:0]                   lo_s;
    logic [CW-1:0]                   hi_s;
    logic [CW-1:0]                   vidx_s;
    logic [CW-1:0]                   cand_idx_s;
    logic [CW-1:0]                   cand_v_s;

    svm_mac #(.W(W), .FRAC(FRAC), .ACC_W(ACC_W), .RELU(RELU)) u_mac (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (mac_en_s),
        .first_i (mac_first_s),
        .bias_i  (mac_bias_s),
        .a_i     (mac_a_s),
        .b_i     (mac_b_s),
        .hid_o   (hid_s),
        .pos_o   (pos_s)
    );

    // Operand muxing for the shared MAC: layer 1 walks d inside h, layer 2 walks h inside p.
    always_comb begin
        mac_en_s    = 1'b0;
        mac_first_s = 1'b0;
        mac_a_s     = '0;
        mac_b_s     = '0;
        mac_bias_s  = '0;
        case (state_q)
            S_L1: begin
                mac_en_s    = 1'b1;
                mac_first_s = (d_q == '0);
                mac_a_s     = din_q[d_q];
                mac_b_s     = feats[d_q][h_q];
                mac_bias_s  = biases[h_q];
            end
            S_L2: begin
                mac_en_s    = 1'b1;
                mac_first_s = (h_q == '0);
                mac_a_s     = hidden_q[h_q];
                mac_b_s     = feats2[h_q][p_q];
                mac_bias_s  = biases2[p_q];
            end
            default: begin
                mac_en_s    = 1'b0;
            end
        endcase
    end

    // Pair decode for voting and the running arg-max candidate (ties keep the lower index).
    always_comb begin
        lo_s   = CW'(pair_lo(int'(p_q), CLASSES));
        hi_s   = CW'(pair_hi(int'(p_q), CLASSES));
        vidx_s = win_q[p_q] ? lo_s : hi_s;
        if (c_q == '0) begin
            cand_idx_s = '0;
            cand_v_s   = votes_q[0];
        end else if (votes_q[c_q] > bestv_q) begin
            cand_idx_s = c_q;
            cand_v_s   = votes_q[c_q];
        end else begin
            cand_idx_s = best_q;
            cand_v_s   = bestv_q;
        end
    end

    // Controller next-state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        din_d       = din_q;
        d_d         = d_q;
        h_d         = h_q;
        p_d         = p_q;
        c_d         = c_q;
        hidden_d    = hidden_q;
        win_d       = win_q;
        votes_d     = votes_q;
        best_d      = best_q;
        bestv_d     = bestv_q;
        class_d     = class_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid_i && in_ready_q) begin
                    din_d      = bus.din;
                    d_d        = '0;
                    h_d        = '0;
                    p_d        = '0;
                    c_d        = '0;
                    votes_d    = '0;
                    in_ready_d = 1'b0;
                    state_d    = S_L1;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            S_L1: begin
                if (d_q == D_LAST) begin
                    hidden_d[h_q] = hid_s;
                    d_d           = '0;
                    if (h_q == H_LAST) begin
                        h_d     = '0;
                        state_d = S_L2;
                    end else begin
                        h_d = h_q + HW'(1);
                    end
                end else begin
                    d_d = d_q + DW'(1);
                end
            end
            S_L2: begin
                if (h_q == H_LAST) begin
                    win_d[p_q] = pos_s;
                    h_d        = '0;
                    if (p_q == P_LAST) begin
                        p_d     = '0;
                        state_d = S_VOTE;
                    end else begin
                        p_d = p_q + PW'(1);
                    end
                end else begin
                    h_d = h_q + HW'(1);
                end
            end
            S_VOTE: begin
                votes_d[vidx_s] = votes_q[vidx_s] + CW'(1);
                if (p_q == P_LAST) begin
                    p_d     = '0;
                    c_d     = '0;
                    state_d = S_ARGMAX;
                end else begin
                    p_d = p_q + PW'(1);
                end
            end
            S_ARGMAX: begin
                best_d  = cand_idx_s;
                bestv_d = cand_v_s;
                if (c_q == C_LAST) begin
                    class_d     = cand_idx_s;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    c_d = c_q + CW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready_i) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any job in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            din_q       <= '0;
            d_q         <= '0;
            h_q         <= '0;
            p_q         <= '0;
            c_q         <= '0;
            hidden_q    <= '0;
            win_q       <= '0;
            votes_q     <= '0;
            best_q      <= '0;
            bestv_q     <= '0;
            class_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            din_q       <= din_d;
            d_q         <= d_d;
            h_q         <= h_d;
            p_q         <= p_d;
            c_q         <= c_d;
            hidden_q    <= hidden_d;
            win_q       <= win_d;
            votes_q     <= votes_d;
            best_q      <= best_d;
            bestv_q     <= bestv_d;
            class_q     <= class_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.class_o     = class_q;
    assign bus.out_valid_o = out_valid_q;
endmodule

// File: tb/tb_svm_seq.sv
// tb_svm_seq: directed-vector bench for svm_seq with hand-computed classes.
module tb_svm_seq;
    localparam int W       = 16;
    localparam int FRAC    = 8;
    localparam int DIMS    = 21;
    localparam int INTER   = 6;
    localparam int CLASSES = 3;
    localparam int NP      = 3;
    localparam int LAT     = 150;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DIMS-1:0][INTER-1:0][W-1:0] feats;
    logic [INTER-1:0][W-1:0]           biases;
    logic [INTER-1:0][NP-1:0][W-1:0]   feats2;
    logic [NP-1:0][W-1:0]              biases2;

    int total = 0;
    int bad   = 0;

    svm_seq_if #(.W(W), .DIMS(DIMS), .CLASSES(CLASSES)) bus ();

    svm_seq #(
        .W(W), .FRAC(FRAC), .DIMS(DIMS), .INTER(INTER), .CLASSES(CLASSES), .RELU(0)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .feats   (feats),
        .biases  (biases),
        .feats2  (feats2),
        .biases2 (biases2),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, present the vector for one accept edge.
    task automatic start_vec(input logic [W-1:0] dval);
        int n;
        n = 0;
        while (bus.in_ready_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_val("ready_before_accept", 32'(bus.in_ready_o), 32'd1);
        for (int d = 0; d < DIMS; d++) begin
            bus.din[d] = dval;
        end
        bus.in_valid_i = 1'b1;
        tick();
        bus.in_valid_i = 1'b0;
        check_val("ready_low_after_accept", 32'(bus.in_ready_o), 32'd0);
    endtask

    // Bounded wait for the result, check latency/class, optional back-pressure, then hand-shake.
    task automatic finish_vec(input string tag, input logic [1:0] exp_cls, input bit bp);
        int cyc;
        int viol;
        cyc = 0;
        while (bus.out_valid_o !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        check_val({tag, "_latency"}, 32'(cyc), 32'(LAT));
        check_val({tag, "_class"}, 32'(bus.class_o), 32'(exp_cls));
        if (bp) begin
            viol = 0;
            for (int i = 0; i < 10; i++) begin
                if (i == 4) begin
                    for (int d = 0; d < DIMS; d++) begin
                        bus.din[d] = 16'h1234;
                    end
                    bus.in_valid_i = 1'b1;
                end
                tick();
                bus.in_valid_i = 1'b0;
                if (bus.out_valid_o !== 1'b1 || bus.class_o !== exp_cls || bus.in_ready_o !== 1'b0) begin
                    viol++;
                end
            end
            check_val({tag, "_bp_stable"}, 32'(viol), 32'd0);
        end
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        check_val({tag, "_valid_drop"}, 32'(bus.out_valid_o), 32'd0);
        check_val({tag, "_ready_back"}, 32'(bus.in_ready_o), 32'd1);
        tick();
        check_val({tag, "_idle_hold"}, 32'(bus.in_ready_o), 32'd1);
    endtask

    initial begin
        feats          = '0;
        biases         = '0;
        feats2         = '0;
        biases2        = '0;
        bus.din        = '0;
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b0;
        repeat (3) tick();
        check_val("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        check_val("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check_val("rst_class", 32'(bus.class_o), 32'd0);
        rst = 1'b0;
        tick();

        // All scores +1.0: lower class wins every pair, votes 2/1/0.
        biases2 = {16'h0100, 16'h0100, 16'h0100};
        start_vec(16'h0000);
        finish_vec("pos", 2'd0, 1'b0);

        // All scores -1.0: higher class wins every pair, votes 0/1/2.
        biases2 = {16'hFF00, 16'hFF00, 16'hFF00};
        start_vec(16'h0000);
        finish_vec("neg", 2'd2, 1'b0);

        // Score exactly zero votes for the higher class.
        biases2 = '0;
        start_vec(16'h0000);
        finish_vec("zero", 2'd2, 1'b0);

        // Reset at cycle 70 of layer 1 while class_o still shows 2.
        biases2 = {16'h0100, 16'hFF00, 16'h0100};
        start_vec(16'h0000);
        repeat (70) tick();
        check_val("pre_rst_class", 32'(bus.class_o), 32'd2);
        rst = 1'b1;
        #1;
        check_val("midrst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check_val("midrst_class", 32'(bus.class_o), 32'd0);
        check_val("midrst_in_ready", 32'(bus.in_ready_o), 32'd1);
        tick();
        rst = 1'b0;
        tick();

        // Tie 1/1/1 after the reset: lowest index wins.
        start_vec(16'h0000);
        finish_vec("tie", 2'd0, 1'b0);

        // Real MAC path: hidden[1] = 21*1.0*0.5 = 10.5; pair(1,2) = 11.0 - 10.5 > 0.
        // Pairs (0,1),(0,2) score 0 -> votes 0/2/1 -> class 1. Also exercises back-pressure.
        for (int d = 0; d < DIMS; d++) begin
            feats[d][1] = 16'h0080;
        end
        feats2[1][2] = 16'hFF00;
        biases2      = {16'h0B00, 16'h0000, 16'h0000};
        start_vec(16'h0100);
        finish_vec("mac_bp", 2'd1, 1'b1);

        // Saturation: hidden[0] clamps to 0x7FFF so pair(0,1) is positive -> class 0.
        feats  = '0;
        feats2 = '0;
        for (int d = 0; d < DIMS; d++) begin
            feats[d][0] = 16'h7FFF;
        end
        feats2[0][0] = 16'h0100;
        biases2      = {16'h0100, 16'h0100, 16'h0000};
        start_vec(16'h7FFF);
        finish_vec("sat", 2'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/svm_seq.md
# svm_seq

Sequential, parametrised successor to the combinational two-layer SVM classifier. It time-multiplexes one signed multiply-accumulate unit over a DIMS→INTER hidden layer and an INTER→NPAIRS one-vs-one score layer, then forms a majority vote over CLASSES. It sits behind the feature front-end with a valid/ready handshake on input and output. Weights and biases arrive as static configuration ports.

## Interface
- W, 16: signed fixed-point data and weight width.
- FRAC, 8: fractional bits of all data, weights and biases.
- DIMS, 21: input feature count.
- INTER, 6: hidden neuron count.
- CLASSES, 3: class count, at least 2. NPAIRS = CLASSES*(CLASSES-1)/2.
- RELU, 0: 1 clamps negative hidden outputs to 0.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  asynchronous, active-high reset.
- feats  in  DIMS×INTER×W  layer-1 weights.
- biases  in  INTER×W  layer-1 biases.
- feats2  in  INTER×NPAIRS×W  score weights.
- biases2  in  NPAIRS×W  score biases.
- din  in  DIMS×W  feature vector.
- in_valid_i  in  1  din valid.
- in_ready_o  out  1  block can accept.
- class_o  out  clog2(CLASSES)  winning class.
- out_valid_o  out  1  class_o valid.
- out_ready_i  in  1  consumer accepts.

## Operation
- States: IDLE → L1 → L2 → VOTE → ARGMAX → DONE → IDLE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&&in_ready_o, register din and go to L1.
- Configuration ports are not registered. They must stay stable from accept until the out_valid_o/out_ready_i handshake.
- L1: for h=0..INTER-1, one product per cycle over d=0..DIMS-1.
  - Accumulator starts at sign-extended biases[h]<<<FRAC.
  - After d=DIMS-1: hidden[h] = sat_W(acc>>>FRAC), using an arithmetic shift and signed saturation to [-2^(W-1), 2^(W-1)-1].
  - If RELU=1, a negative result becomes 0.
- L2: for p=0..NPAIRS-1, accumulate over INTER hidden values, starting from biases2[p]<<<FRAC.
  - Store only the sign bit: win[p] = (acc > 0).
- Pair order p: (0,1),(0,2),…,(0,C-1),(1,2),…,(C-2,C-1).
- VOTE: one pair per cycle.
  - win[p]=1 increments the vote of the lower class i. Otherwise it increments the higher class j.
  - A score of exactly 0 votes for j.
- ARGMAX: one class per cycle. Ties go to the lowest index.
- Arithmetic widths:
  - Product width is 2W.
  - ACC_W = 2W+clog2(max(DIMS,INTER)+1). The accumulator never wraps.
  - Vote counters are clog2(CLASSES) bits wide.
- DONE:
  - out_valid_o=1 and class_o is held stable.
  - When out_ready_i=1, go to IDLE in the next cycle.
  - in_ready_o=0 in every state except IDLE. No overlap between vectors.
- Reset, asynchronous at any point including mid-operation:
  - State returns to IDLE.
  - out_valid_o=0, class_o=0, in_ready_o=1.
  - Accumulator, hidden registers and votes are cleared.
  - The partial result is discarded.

## Timing
- Latency L = DIMS*INTER + INTER*NPAIRS + NPAIRS + CLASSES cycles, counted from the accept edge to the first edge at which out_valid_o=1. Defaults give L=150.
- out_valid_o and class_o are registered outputs.
- An accept in IDLE at edge t leaves in_ready_o=0 from t onward.
- An output handshake at edge t gives IDLE and in_ready_o=1 after t. The earliest next accept is at t+1.
- in_valid_i is ignored outside IDLE.
- Throughput is one vector per L+2 cycles when neither side stalls.

## Structure
- Package svm_pkg contains:
  - the state enum;
  - functions npairs(C), pair_lo(p,C), pair_hi(p,C) and acc_w(W,DIMS,INTER);
  - the sat function.
- Sub-module svm_mac contains:
  - the signed W×W multiplier and ACC_W accumulator;
  - a bias-preload input;
  - the shift/saturate/ReLU output path.
- The top level contains:
  - the FSM;
  - d/h/p/c counters;
  - operand muxing;
  - the hidden register file;
  - the vote counters.

## Test plan
Configuration for all scenarios: W=16, FRAC=8, DIMS=21, INTER=6, CLASSES=3.
- All weights 0, biases2={0x0100,0x0100,0x0100} → class_o=0 (votes 2/1/0). Check out_valid_o exactly 150 cycles after accept.
- All weights 0, biases2={0xFF00,0xFF00,0xFF00} → class_o=2. All-zero biases2 → class_o=2 (zero votes high).
- Tie: biases2={+1.0,-1.0,+1.0} gives 1/1/1 → class_o=0.
- Saturation: din all 0x7FFF, feats[*][0]=0x7FFF, other feats 0, feats2[0][0]=0x0100, biases2={0,+1.0,+1.0} → class_o=0. A wrapping implementation gives 1.
- Back-pressure: hold out_ready_i=0 for 10 cycles.
  - class_o and out_valid_o stay stable.
  - in_ready_o stays 0 and an in_valid_i pulse is ignored.
  - After release, in_ready_o=1 on the next cycle.
- Reset at cycle 70 of L1:
  - outputs go immediately to out_valid_o=0, class_o=0, in_ready_o=1.
  - A fresh vector then completes in 150 cycles with the correct class.
